clk_div_cfg_sequencer: RTL

Upstream control stage for the logic clock divider. It accepts divider-ratio requests over a valid/ready handshake and drives the divider's `divider_cycles` input. Each new ratio is applied only just after a falling edge of the fed-back divided clock, so the output never produces a runt pulse. Requests come from AXI-mapped control registers; `divider_cycles` connects straight to the divider in the same `master_clk` domain.

---
 rtl/clk_div_cfg_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/clk_div_cfg_sequencer.sv
// clk_div_cfg_sequencer: applies new divider ratios just after a falling edge of the divided clock; CLK_DIV_RAMP_EN enables stepped ramping
module clk_div_cfg_sequencer #(
  parameter int                      COUNTER_BITS   = 32,
  parameter logic [COUNTER_BITS-1:0] RESET_DIVIDER  = '0,
  parameter int                      SETTLE_CYCLES  = 4,
  parameter int                      TIMEOUT_CYCLES = 65536,
  parameter int                      RAMP_STEP      = 1
) (
  input  logic                    master_clk,
  input  logic                    axi_resetn,
  input  logic [COUNTER_BITS-1:0] req_divider,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    div_clk_level,
  output logic [COUNTER_BITS-1:0] divider_cycles,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  input  logic                    clear_err
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_EDGE = 2'd1;
  localparam logic [1:0] APPLY     = 2'd2;
  localparam logic [1:0] SETTLE    = 2'd3;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  logic [1:0]              state_q, state_d;
  logic [COUNTER_BITS-1:0] target_q, target_d;
  logic [COUNTER_BITS-1:0] div_q, div_d;
  logic [COUNTER_BITS-1:0] next_div;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [SW-1:0]           scnt_q, scnt_d;
  logic                    prev_q, done_q, done_d, terr_q, terr_d;
  logic                    accept, fall, tmo;
  assign accept = req_valid & (state_q == IDLE);
  assign fall   = prev_q & ~div_clk_level;
  assign tmo    = (TIMEOUT_CYCLES != 0) && (tcnt_q == T_LAST);
`ifdef CLK_DIV_RAMP_EN
  localparam logic [COUNTER_BITS-1:0] STEP = COUNTER_BITS'(RAMP_STEP);
  logic                    up;
  logic [COUNTER_BITS-1:0] gap;
  assign up       = target_q > div_q;
  assign gap      = up ? target_q - div_q : div_q - target_q;
  assign next_div = gap > STEP ? (up ? div_q + STEP : div_q - STEP) : target_q;
`else
  logic unused_ramp;
  assign unused_ramp = ^COUNTER_BITS'(RAMP_STEP);
  assign next_div    = target_q;
`endif
  assign req_ready      = state_q == IDLE;
  assign busy           = state_q != IDLE;
  assign done           = done_q;
  assign timeout_err    = terr_q;
  assign divider_cycles = div_q;
  // next-state logic: handshake, edge wait with timeout, single-cycle apply, settle
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    div_d    = div_q;
    tcnt_d   = tcnt_q;
    scnt_d   = '0;
    done_d   = 1'b0;
    terr_d   = terr_q & ~clear_err;
    case (state_q)
      IDLE: if (accept) begin
        target_d = req_divider;
        tcnt_d   = '0;
        done_d   = req_divider == div_q;
        state_d  = req_divider == div_q ? IDLE : div_q == '0 ? APPLY : WAIT_EDGE;
      end
      WAIT_EDGE: begin
        tcnt_d = tcnt_q + 1'b1;
        if (fall | tmo) begin
          state_d = APPLY;
          terr_d  = terr_d | ~fall;
        end
      end
      APPLY: begin
        div_d   = next_div;
        state_d = SETTLE;
      end
      default: if (scnt_q == S_LAST) begin
        done_d  = div_q == target_q;
        tcnt_d  = '0;
        state_d = div_q == target_q ? IDLE : div_q == '0 ? APPLY : WAIT_EDGE;
      end else scnt_d = scnt_q + 1'b1;
    endcase
  end
  // state registers; reset drops any pending request without a done pulse
  always_ff @(posedge master_clk or negedge axi_resetn)
    if (!axi_resetn) begin
      state_q  <= IDLE;
      target_q <= '0;
      div_q    <= RESET_DIVIDER;
      tcnt_q   <= '0;
      scnt_q   <= '0;
      prev_q   <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      div_q    <= div_d;
      tcnt_q   <= tcnt_d;
      scnt_q   <= scnt_d;
      prev_q   <= div_clk_level;
      done_q   <= done_d;
      terr_q   <= terr_d;
    end
endmodule
